alu_op_decoder: RTL and testbench

// - Driving end of the ALU Function interface: decodes 32-bit MIPS instruction words into the 4-bit ALU

---
 rtl/alu_op_decoder_if.sv | 37 +++
 rtl/alu_op_decoder.sv | 151 +++++++++++++++
 tb/tb_alu_op_decoder.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_decoder_if.sv
// rtl/alu_op_decoder_if.sv - instruction-in / decoded-packet-out handshake bundle for alu_op_decoder
// ALU_DEC_ILLEGAL_DROP_EN adds the sticky illegal_seen flag.
interface alu_op_decoder_if #(
    parameter int TAG_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       alu_fn;
    logic             b_imm;
    logic             imm_zext;
    logic             use_shamt;
    logic             illegal;
    logic [TAG_W-1:0] out_tag;
`ifdef ALU_DEC_ILLEGAL_DROP_EN
    logic             illegal_seen;
`endif

    modport master (
        output in_valid, in_instr, in_tag, out_ready,
`ifdef ALU_DEC_ILLEGAL_DROP_EN
        input  illegal_seen,
`endif
        input  in_ready, out_valid, alu_fn, b_imm, imm_zext, use_shamt, illegal, out_tag
    );

    modport slave (
        input  in_valid, in_instr, in_tag, out_ready,
`ifdef ALU_DEC_ILLEGAL_DROP_EN
        output illegal_seen,
`endif
        output in_ready, out_valid, alu_fn, b_imm, imm_zext, use_shamt, illegal, out_tag
    );
endinterface

// File: rtl/alu_op_decoder.sv
// rtl/alu_op_decoder.sv - MIPS instruction to ALU function decoder with 2-entry skid buffer
// ALU_DEC_ILLEGAL_DROP_EN: swallow illegal instructions and raise sticky illegal_seen instead.
module alu_op_decoder #(
    parameter int         TAG_W      = 32,
    parameter logic [3:0] ILLEGAL_FN = 4'b1111
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    alu_op_decoder_if.slave  bus
);
    localparam logic [3:0] FN_ADD = 4'b0000;
    localparam logic [3:0] FN_SUB = 4'b0010;
    localparam logic [3:0] FN_AND = 4'b0100;
    localparam logic [3:0] FN_OR  = 4'b0101;
    localparam logic [3:0] FN_NOR = 4'b0110;
    localparam logic [3:0] FN_XOR = 4'b0111;
    localparam logic [3:0] FN_SL  = 4'b1000;
    localparam logic [3:0] FN_SRA = 4'b1001;
    localparam logic [3:0] FN_SRL = 4'b1010;

    typedef struct packed {
        logic [3:0]       fn;
        logic             b_imm;
        logic             imm_zext;
        logic             use_shamt;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } pkt_t;

    pkt_t       dec;
    pkt_t       slot0;
    pkt_t       slot1;
    logic [1:0] count;
    logic [1:0] count_next;
    logic       ready_q;
    logic       legal;
    logic       accept;
    logic       push;
    logic       pop;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_instr_bits;

    assign opcode            = bus.in_instr[31:26];
    assign funct             = bus.in_instr[5:0];
    assign unused_instr_bits = ^bus.in_instr[25:6];

    always_comb begin
        dec       = '0;
        dec.tag   = bus.in_tag;
        legal     = 1'b1;
        case (opcode)
            6'b000000: begin
                case (funct)
                    6'b100000, 6'b100001: dec.fn = FN_ADD;
                    6'b100010, 6'b100011: dec.fn = FN_SUB;
                    6'b100100: dec.fn = FN_AND;
                    6'b100101: dec.fn = FN_OR;
                    6'b100110: dec.fn = FN_XOR;
                    6'b100111: dec.fn = FN_NOR;
                    6'b000000: begin dec.fn = FN_SL;  dec.use_shamt = 1'b1; end
                    6'b000010: begin dec.fn = FN_SRL; dec.use_shamt = 1'b1; end
                    6'b000011: begin dec.fn = FN_SRA; dec.use_shamt = 1'b1; end
                    6'b000100: dec.fn = FN_SL;
                    6'b000110: dec.fn = FN_SRL;
                    6'b000111: dec.fn = FN_SRA;
                    default:   legal = 1'b0;
                endcase
            end
            6'b001000, 6'b001001, 6'b100011, 6'b101011: begin
                dec.fn    = FN_ADD;
                dec.b_imm = 1'b1;
            end
            6'b001100: begin dec.fn = FN_AND; dec.b_imm = 1'b1; dec.imm_zext = 1'b1; end
            6'b001101: begin dec.fn = FN_OR;  dec.b_imm = 1'b1; dec.imm_zext = 1'b1; end
            6'b001110: begin dec.fn = FN_XOR; dec.b_imm = 1'b1; dec.imm_zext = 1'b1; end
            6'b000100, 6'b000101: dec.fn = FN_SUB;
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec.fn        = ILLEGAL_FN;
            dec.b_imm     = 1'b0;
            dec.imm_zext  = 1'b0;
            dec.use_shamt = 1'b0;
            dec.illegal   = 1'b1;
        end
    end

    assign accept = bus.in_valid & ready_q & ~flush;
`ifdef ALU_DEC_ILLEGAL_DROP_EN
    assign push   = accept & ~dec.illegal;
`else
    assign push   = accept;
`endif
    assign pop    = (count != 2'd0) & bus.out_ready;

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + 2'd1;
        else if (pop && !push)
            count_next = count - 2'd1;
    end

    // slot0 is the presented head; it is left untouched when the buffer drains so outputs hold
    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= 2'd0;
            ready_q <= 1'b0;
            slot0   <= '0;
            slot1   <= '0;
        end else if (flush) begin
            count   <= 2'd0;
            ready_q <= 1'b1;
        end else begin
            count   <= count_next;
            ready_q <= (count_next != 2'd2);
            if (pop && count == 2'd2)
                slot0 <= slot1;
            if (push) begin
                if (count == 2'd0 || (count == 2'd1 && pop))
                    slot0 <= dec;
                else
                    slot1 <= dec;
            end
        end
    end

`ifdef ALU_DEC_ILLEGAL_DROP_EN
    logic seen_q;
    always_ff @(posedge clk) begin
        if (rst)
            seen_q <= 1'b0;
        else if (accept && dec.illegal)
            seen_q <= 1'b1;
    end
    assign bus.illegal_seen = seen_q;
    assign bus.illegal      = 1'b0;
`else
    assign bus.illegal      = slot0.illegal;
`endif

    assign bus.in_ready  = ready_q;
    assign bus.out_valid = (count != 2'd0);
    assign bus.alu_fn    = slot0.fn;
    assign bus.b_imm     = slot0.b_imm;
    assign bus.imm_zext  = slot0.imm_zext;
    assign bus.use_shamt = slot0.use_shamt;
    assign bus.out_tag   = slot0.tag;
endmodule

// File: tb/tb_alu_op_decoder.sv
// tb/tb_alu_op_decoder.sv - randomized and directed check of alu_op_decoder against a queue model
module tb_alu_op_decoder;
    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    alu_op_decoder_if #(.TAG_W(32)) bus();

    alu_op_decoder #(.TAG_W(32), .ILLEGAL_FN(4'b1111)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    typedef struct {
        logic [5:0] op;
        logic       rtype;
        logic [5:0] fn6;
        logic [3:0] alu;
        logic       bi;
        logic       zx;
        logic       sh;
    } rule_t;

    typedef struct packed {
        logic [3:0]  fn;
        logic        bi;
        logic        zx;
        logic        sh;
        logic        ill;
        logic [31:0] tag;
    } exp_t;

    rule_t rules[$];
    exp_t  q[$];
    exp_t  m_last;
    logic  m_ready;
    logic  m_seen;
    logic  last_acc;
    int    total = 0;
    int    bad   = 0;

    function automatic void add_rule(input logic [5:0] op, input logic rt, input logic [5:0] f,
                                     input logic [3:0] a, input logic bi, input logic zx, input logic sh);
        rule_t r;
        r.op = op; r.rtype = rt; r.fn6 = f; r.alu = a; r.bi = bi; r.zx = zx; r.sh = sh;
        rules.push_back(r);
    endfunction

    function automatic exp_t model_decode(input logic [31:0] ins, input logic [31:0] tg);
        exp_t e;
        e = '{fn: 4'b1111, bi: 1'b0, zx: 1'b0, sh: 1'b0, ill: 1'b1, tag: tg};
        foreach (rules[i]) begin
            if (rules[i].op == ins[31:26] && (!rules[i].rtype || rules[i].fn6 == ins[5:0])) begin
                e.fn = rules[i].alu; e.bi = rules[i].bi; e.zx = rules[i].zx;
                e.sh = rules[i].sh; e.ill = 1'b0;
            end
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_outputs();
        chk("in_ready", 64'(bus.in_ready), 64'(m_ready));
        chk("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
        chk("alu_fn", 64'(bus.alu_fn), 64'(m_last.fn));
        chk("b_imm", 64'(bus.b_imm), 64'(m_last.bi));
        chk("imm_zext", 64'(bus.imm_zext), 64'(m_last.zx));
        chk("use_shamt", 64'(bus.use_shamt), 64'(m_last.sh));
        chk("out_tag", 64'(bus.out_tag), 64'(m_last.tag));
`ifdef ALU_DEC_ILLEGAL_DROP_EN
        chk("illegal", 64'(bus.illegal), 64'(0));
        chk("illegal_seen", 64'(bus.illegal_seen), 64'(m_seen));
`else
        chk("illegal", 64'(bus.illegal), 64'(m_last.ill));
`endif
    endtask

    // One clock: drive, let the edge happen, advance the model, compare on the falling edge
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] tg,
                        input logic ordy, input logic fl, input logic r);
        exp_t d;
        logic acc;
        logic pp;
        bus.in_valid = v; bus.in_instr = ins; bus.in_tag = tg;
        bus.out_ready = ordy; flush = fl; rst = r;
        d   = model_decode(ins, tg);
        acc = v && m_ready && !fl && !r;
        pp  = (q.size() > 0) && ordy;
        @(posedge clk);
        if (r) begin
            q.delete(); m_ready = 1'b0; m_last = '0; m_seen = 1'b0;
        end else if (fl) begin
            q.delete(); m_ready = 1'b1;
        end else begin
            if (pp) void'(q.pop_front());
`ifdef ALU_DEC_ILLEGAL_DROP_EN
            if (acc && d.ill) m_seen = 1'b1;
            if (acc && !d.ill) q.push_back(d);
`else
            if (acc) q.push_back(d);
`endif
            m_ready = (q.size() < 2);
        end
        if (q.size() > 0) m_last = q[0];
        last_acc = acc;
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic present_until_accepted(input logic [31:0] ins, input logic [31:0] tg, input logic ordy);
        int n = 0;
        do begin
            step(1'b1, ins, tg, ordy, 1'b0, 1'b0);
            n++;
        end while (!last_acc && n < 20);
        if (!last_acc) begin
            total++; bad++;
            $display("FAIL accept_timeout actual=0 required=1 tag=%0h", tg);
        end
    endtask

    exp_t e;
    logic [31:0] ins;
    rule_t rr;

    initial begin
        add_rule(6'b000000, 1, 6'b100000, 4'b0000, 0, 0, 0);
        add_rule(6'b000000, 1, 6'b100001, 4'b0000, 0, 0, 0);
        add_rule(6'b000000, 1, 6'b100010, 4'b0010, 0, 0, 0);
        add_rule(6'b000000, 1, 6'b100011, 4'b0010, 0, 0, 0);
        add_rule(6'b000000, 1, 6'b100100, 4'b0100, 0, 0, 0);
        add_rule(6'b000000, 1, 6'b100101, 4'b0101, 0, 0, 0);
        add_rule(6'b000000, 1, 6'b100110, 4'b0111, 0, 0, 0);
        add_rule(6'b000000, 1, 6'b100111, 4'b0110, 0, 0, 0);
        add_rule(6'b000000, 1, 6'b000000, 4'b1000, 0, 0, 1);
        add_rule(6'b000000, 1, 6'b000010, 4'b1010, 0, 0, 1);
        add_rule(6'b000000, 1, 6'b000011, 4'b1001, 0, 0, 1);
        add_rule(6'b000000, 1, 6'b000100, 4'b1000, 0, 0, 0);
        add_rule(6'b000000, 1, 6'b000110, 4'b1010, 0, 0, 0);
        add_rule(6'b000000, 1, 6'b000111, 4'b1001, 0, 0, 0);
        add_rule(6'b001000, 0, 6'b0, 4'b0000, 1, 0, 0);
        add_rule(6'b001001, 0, 6'b0, 4'b0000, 1, 0, 0);
        add_rule(6'b100011, 0, 6'b0, 4'b0000, 1, 0, 0);
        add_rule(6'b101011, 0, 6'b0, 4'b0000, 1, 0, 0);
        add_rule(6'b001100, 0, 6'b0, 4'b0100, 1, 1, 0);
        add_rule(6'b001101, 0, 6'b0, 4'b0101, 1, 1, 0);
        add_rule(6'b001110, 0, 6'b0, 4'b0111, 1, 1, 0);
        add_rule(6'b000100, 0, 6'b0, 4'b0010, 0, 0, 0);
        add_rule(6'b000101, 0, 6'b0, 4'b0010, 0, 0, 0);

        // Pin the reference decoder to hand-decoded words
        e = model_decode(32'h012A4020, 32'h0);
        chk("model_add", {e.fn, e.bi, e.zx, e.sh, e.ill}, {4'b0000, 4'b0000});
        e = model_decode(32'h312800FF, 32'h0);
        chk("model_andi", {e.fn, e.bi, e.zx, e.sh, e.ill}, {4'b0100, 4'b1100});
        e = model_decode(32'h00094083, 32'h0);
        chk("model_sra", {e.fn, e.bi, e.zx, e.sh, e.ill}, {4'b1001, 4'b0010});
        e = model_decode(32'hFC000000, 32'h0);
        chk("model_illegal", {e.fn, e.bi, e.zx, e.sh, e.ill}, {4'b1111, 4'b0001});

        m_ready = 1'b0; m_last = '0; m_seen = 1'b0; last_acc = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("reset_in_ready", 64'(bus.in_ready), 64'(0));
        chk("reset_out_valid", 64'(bus.out_valid), 64'(0));
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("ready_after_reset", 64'(bus.in_ready), 64'(1));

        step(1'b1, 32'h012A4020, 32'h100, 1'b1, 1'b0, 1'b0);
        chk("add_valid", 64'(bus.out_valid), 64'(1));
        chk("add_fn", 64'(bus.alu_fn), 64'(4'b0000));
        step(1'b1, 32'h312800FF, 32'h101, 1'b1, 1'b0, 1'b0);
        chk("andi_fields", 64'({bus.alu_fn, bus.b_imm, bus.imm_zext}), 64'({4'b0100, 2'b11}));
        step(1'b1, 32'h00094083, 32'h102, 1'b1, 1'b0, 1'b0);
        chk("sra_fields", 64'({bus.alu_fn, bus.use_shamt}), 64'({4'b1001, 1'b1}));
        step(1'b1, 32'hFC000000, 32'h103, 1'b1, 1'b0, 1'b0);
`ifdef ALU_DEC_ILLEGAL_DROP_EN
        chk("drop_no_packet", 64'(bus.out_valid), 64'(0));
        chk("drop_seen", 64'(bus.illegal_seen), 64'(1));
`else
        chk("illegal_packet", 64'({bus.out_valid, bus.illegal, bus.alu_fn}), 64'({2'b11, 4'b1111}));
`endif
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Backpressure: tag 3 must wait, then 1,2,3 drain back-to-back
        step(1'b1, 32'h012A4020, 32'd1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h012A4020, 32'd2, 1'b0, 1'b0, 1'b0);
        chk("bp_in_ready", 64'(bus.in_ready), 64'(0));
        step(1'b1, 32'h012A4020, 32'd3, 1'b0, 1'b0, 1'b0);
        chk("bp_tag3_held", 64'(last_acc), 64'(0));
        chk("bp_head", 64'(bus.out_tag), 64'(1));
        present_until_accepted(32'h012A4020, 32'd3, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Flush with two buffered entries and a same-cycle input
        step(1'b1, 32'h01095022, 32'd10, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h01095022, 32'd11, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h01095022, 32'd12, 1'b0, 1'b1, 1'b0);
        chk("flush_out_valid", 64'(bus.out_valid), 64'(0));
        chk("flush_in_ready", 64'(bus.in_ready), 64'(1));
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("flush_dropped", 64'(bus.out_valid), 64'(0));

        // Same again with reset instead of flush
        step(1'b1, 32'h35280F0F, 32'd20, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h35280F0F, 32'd21, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h35280F0F, 32'd22, 1'b0, 1'b0, 1'b1);
        chk("rst_outputs", 64'({bus.out_valid, bus.in_ready, bus.alu_fn, bus.b_imm, bus.imm_zext,
                                bus.use_shamt, bus.illegal}), 64'(0));
        chk("rst_out_tag", 64'(bus.out_tag), 64'(0));
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Sustained push+pop at occupancy 1
        step(1'b1, 32'h012A4020, 32'd30, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 32'h012A4022, 32'd31 + 32'(i), 1'b1, 1'b0, 1'b0);
            chk("steady_in_ready", 64'(bus.in_ready), 64'(1));
            chk("steady_head", 64'(bus.out_tag), 64'(32'd31 + 32'(i)));
        end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                rr = rules[$urandom_range(0, rules.size() - 1)];
                ins = $urandom;
                ins[31:26] = rr.op;
                if (rr.rtype) ins[5:0] = rr.fn6;
            end else begin
                ins = $urandom;
            end
            step($urandom_range(0, 3) != 0, ins, $urandom, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 40) == 0, $urandom_range(0, 250) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
